// File: rtl/ptc_axi_rq_skid.sv
// Two-entry skid buffer between the MFB-to-AXI converter and the PCIe RQ port.
// RX_READY is registered; packet and stall statistics saturate.
module ptc_axi_rq_skid #(
    parameter int AXI_DATA_WIDTH   = 512,
    parameter int AXI_RQUSER_WIDTH = 137,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [AXI_DATA_WIDTH-1:0]     RX_DATA,
    input  logic [AXI_RQUSER_WIDTH-1:0]   RX_USER,
    input  logic                          RX_LAST,
    input  logic [AXI_DATA_WIDTH/32-1:0]  RX_KEEP,
    input  logic                          RX_VALID,
    output logic                          RX_READY,
    output logic [AXI_DATA_WIDTH-1:0]     TX_DATA,
    output logic [AXI_RQUSER_WIDTH-1:0]   TX_USER,
    output logic                          TX_LAST,
    output logic [AXI_DATA_WIDTH/32-1:0]  TX_KEEP,
    output logic                          TX_VALID,
    input  logic                          TX_READY,
    input  logic                          CNT_CLR,
    output logic [CNT_WIDTH-1:0]          CNT_PKTS,
    output logic [CNT_WIDTH-1:0]          CNT_STALL,
    output logic                          TX_IN_PKT
);

    localparam int KW = AXI_DATA_WIDTH / 32;
    localparam int WW = AXI_DATA_WIDTH + AXI_RQUSER_WIDTH + 1 + KW;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] main_q;
    logic [WW-1:0] skid_q;
    logic [WW-1:0] rx_word;
    logic          rx_ready_q;
    logic          rx_xfer;
    logic          tx_xfer;
    logic          load_main;
    logic          load_skid;
    logic          move_skid;

    assign rx_word  = {RX_DATA, RX_USER, RX_LAST, RX_KEEP};
    assign TX_VALID = (state != EMPTY);
    assign RX_READY = rx_ready_q;
    assign rx_xfer  = RX_VALID & rx_ready_q;
    assign tx_xfer  = TX_VALID & TX_READY;

    assign {TX_DATA, TX_USER, TX_LAST, TX_KEEP} = main_q;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (rx_xfer) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (rx_xfer && !tx_xfer) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (tx_xfer && !rx_xfer) begin
                    state_nxt = EMPTY;
                end else if (rx_xfer && tx_xfer) begin
                    load_main = 1'b1;
                end
            end
            TWO: begin
                if (tx_xfer) begin
                    state_nxt = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= EMPTY;
            rx_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_ready_q <= (state_nxt != TWO);
        end
    end

    // Payload registers carry no reset; they are only observed with TX_VALID=1.
    always_ff @(posedge CLK) begin
        if (load_main) begin
            main_q <= rx_word;
        end else if (move_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= rx_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT_PKTS  <= '0;
            CNT_STALL <= '0;
            TX_IN_PKT <= 1'b0;
        end else begin
            if (CNT_CLR) begin
                CNT_PKTS <= '0;
            end else if (tx_xfer && TX_LAST && CNT_PKTS != '1) begin
                CNT_PKTS <= CNT_PKTS + CNT_ONE;
            end
            if (CNT_CLR) begin
                CNT_STALL <= '0;
            end else if (TX_VALID && !TX_READY && CNT_STALL != '1) begin
                CNT_STALL <= CNT_STALL + CNT_ONE;
            end
            if (tx_xfer) begin
                TX_IN_PKT <= ~TX_LAST;
            end
        end
    end

endmodule

// File: tb/tb_ptc_axi_rq_skid.sv
// Directed and randomized checks of the RQ skid buffer: latency, ordering,
// backpressure, counters, saturation and mid-packet reset.
module tb_ptc_axi_rq_skid;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 32;
    localparam int WW = DW + UW + 1 + KW;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic [UW-1:0] rx_user = '0;
    logic          rx_last = 1'b0;
    logic [KW-1:0] rx_keep = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic [UW-1:0] tx_user;
    logic          tx_last;
    logic [KW-1:0] tx_keep;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] cnt_pkts;
    logic [CW-1:0] cnt_stall;
    logic          tx_in_pkt;

    logic          b_rx_ready;
    logic [DW-1:0] b_tx_data;
    logic [UW-1:0] b_tx_user;
    logic          b_tx_last;
    logic [KW-1:0] b_tx_keep;
    logic          b_tx_valid;
    logic [3:0]    b_cnt_pkts;
    logic [3:0]    b_cnt_stall;
    logic          b_tx_in_pkt;

    logic [WW-1:0] tx_word;
    assign tx_word = {tx_data, tx_user, tx_last, tx_keep};

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    ptc_axi_rq_skid #(
        .AXI_DATA_WIDTH(DW), .AXI_RQUSER_WIDTH(UW), .CNT_WIDTH(CW)
    ) dut (
        .CLK(clk), .RST(rst),
        .RX_DATA(rx_data), .RX_USER(rx_user), .RX_LAST(rx_last),
        .RX_KEEP(rx_keep), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .TX_DATA(tx_data), .TX_USER(tx_user), .TX_LAST(tx_last),
        .TX_KEEP(tx_keep), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .CNT_CLR(cnt_clr), .CNT_PKTS(cnt_pkts), .CNT_STALL(cnt_stall),
        .TX_IN_PKT(tx_in_pkt)
    );

    ptc_axi_rq_skid #(
        .AXI_DATA_WIDTH(DW), .AXI_RQUSER_WIDTH(UW), .CNT_WIDTH(4)
    ) dut_sat (
        .CLK(clk), .RST(rst),
        .RX_DATA(rx_data), .RX_USER(rx_user), .RX_LAST(rx_last),
        .RX_KEEP(rx_keep), .RX_VALID(rx_valid), .RX_READY(b_rx_ready),
        .TX_DATA(b_tx_data), .TX_USER(b_tx_user), .TX_LAST(b_tx_last),
        .TX_KEEP(b_tx_keep), .TX_VALID(b_tx_valid), .TX_READY(tx_ready),
        .CNT_CLR(cnt_clr), .CNT_PKTS(b_cnt_pkts), .CNT_STALL(b_cnt_stall),
        .TX_IN_PKT(b_tx_in_pkt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] mk(input int idx, input logic last);
        logic [31:0] a;
        a = 32'(idx);
        return {32'hD000_0000 + a, a * 32'd3, a[15:0] ^ 16'h5A5A, last, a[1:0]};
    endfunction

    task automatic set_rx(input logic [WW-1:0] w, input logic v);
        {rx_data, rx_user, rx_last, rx_keep} = w;
        rx_valid = v;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        ntests++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
            nfail++;
            $display("FAIL reset_hs: tx_valid=%b rx_ready=%b, want 0 0", tx_valid, rx_ready);
        end
        ntests++;
        if (cnt_pkts !== '0 || cnt_stall !== '0 || tx_in_pkt !== 1'b0) begin
            nfail++;
            $display("FAIL reset_cnt: pkts=%0d stall=%0d in_pkt=%b, want 0 0 0",
                     cnt_pkts, cnt_stall, tx_in_pkt);
        end
        rst = 1'b0;
        tick();
        ntests++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release: rx_ready=%b tx_valid=%b, want 1 0", rx_ready, tx_valid);
        end
    endtask

    task automatic test_streaming();
        clear_cnt();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_rx(mk(100 + i, i == 2), 1'b1);
            else rx_valid = 1'b0;
            if (i < 3) begin
                ntests++;
                if (rx_ready !== 1'b1) begin
                    nfail++;
                    $display("FAIL stream_ready[%0d]: got %b want 1", i, rx_ready);
                end
            end
            if (i > 0) begin
                ntests++;
                if (tx_valid !== 1'b1 || tx_word !== mk(100 + i - 1, i == 3)) begin
                    nfail++;
                    $display("FAIL stream_word[%0d]: valid=%b word=%h want %h",
                             i, tx_valid, tx_word, mk(100 + i - 1, i == 3));
                end
            end
            tick();
        end
        ntests++;
        if (tx_valid !== 1'b0 || cnt_pkts !== 16'd1 || cnt_stall !== 16'd0) begin
            nfail++;
            $display("FAIL stream_end: valid=%b pkts=%0d stall=%0d, want 0 1 0",
                     tx_valid, cnt_pkts, cnt_stall);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcvd = 0;
        clear_cnt();
        for (int cyc = 0; cyc < 40; cyc++) begin
            tx_ready = !(cyc >= 1 && cyc <= 5);
            if (sent < 6) set_rx(mk(200 + sent, sent == 5), 1'b1);
            else rx_valid = 1'b0;
            if (cyc >= 2 && cyc <= 5) begin
                ntests++;
                if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || tx_word !== mk(200, 1'b0)) begin
                    nfail++;
                    $display("FAIL bp_hold[%0d]: rx_ready=%b valid=%b word=%h want 0 1 %h",
                             cyc, rx_ready, tx_valid, tx_word, mk(200, 1'b0));
                end
            end
            if (cyc == 6) begin
                ntests++;
                if (sent != 2) begin
                    nfail++;
                    $display("FAIL bp_accepted: got %0d want 2", sent);
                end
            end
            if (tx_valid && tx_ready) begin
                ntests++;
                if (tx_word !== mk(200 + rcvd, rcvd == 5)) begin
                    nfail++;
                    $display("FAIL bp_word[%0d]: got %h want %h",
                             rcvd, tx_word, mk(200 + rcvd, rcvd == 5));
                end
                rcvd++;
            end
            if (rx_valid && rx_ready) sent++;
            tick();
        end
        tx_ready = 1'b1;
        ntests++;
        if (rcvd != 6 || cnt_stall !== 16'd5 || cnt_pkts !== 16'd1) begin
            nfail++;
            $display("FAIL bp_end: rcvd=%0d stall=%0d pkts=%0d, want 6 5 1",
                     rcvd, cnt_stall, cnt_pkts);
        end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [WW-1:0] q[$];
        logic [WW-1:0] exp_w;
        logic [WW-1:0] prev_w = '0;
        logic          hold = 1'b0;
        logic          model_in = 1'b0;
        logic          acc;
        int sent = 0;
        int got = 0;
        int exp_pkts = 0;
        int nprint = 0;
        int cyc = 0;
        clear_cnt();
        rx_valid = 1'b0;
        while (got < N && cyc < 60000) begin
            acc = 1'b0;
            if (!rx_valid && sent < N && $urandom_range(3) != 0) begin
                set_rx({$urandom(), $urandom(), 16'($urandom()),
                        (sent == N - 1) || ($urandom_range(3) == 0), 2'($urandom())}, 1'b1);
            end
            tx_ready = ($urandom_range(3) != 0);
            if (hold) begin
                ntests++;
                if (tx_valid !== 1'b1 || tx_word !== prev_w) begin
                    nfail++;
                    if (nprint++ < 10)
                        $display("FAIL rand_stable: valid=%b word=%h want 1 %h",
                                 tx_valid, tx_word, prev_w);
                end
            end
            hold = tx_valid && !tx_ready;
            prev_w = tx_word;
            ntests++;
            if (tx_in_pkt !== model_in) begin
                nfail++;
                if (nprint++ < 10)
                    $display("FAIL rand_in_pkt: got %b want %b", tx_in_pkt, model_in);
            end
            if (tx_valid && tx_ready) begin
                exp_w = (q.size() > 0) ? q.pop_front() : '0;
                ntests++;
                if (tx_word !== exp_w) begin
                    nfail++;
                    if (nprint++ < 10)
                        $display("FAIL rand_word[%0d]: got %h want %h", got, tx_word, exp_w);
                end
                if (exp_w[KW]) exp_pkts++;
                model_in = ~exp_w[KW];
                got++;
            end
            if (rx_valid && rx_ready) begin
                q.push_back({rx_data, rx_user, rx_last, rx_keep});
                sent++;
                acc = 1'b1;
            end
            tick();
            cyc++;
            if (acc) rx_valid = 1'b0;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        ntests++;
        if (got != N || q.size() != 0) begin
            nfail++;
            $display("FAIL rand_count: got=%0d left=%0d want %0d 0", got, q.size(), N);
        end
        ntests++;
        if (cnt_pkts !== CW'(exp_pkts)) begin
            nfail++;
            $display("FAIL rand_pkts: got %0d want %0d", cnt_pkts, exp_pkts);
        end
    endtask

    task automatic test_saturation();
        int sent = 0;
        int got = 0;
        clear_cnt();
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            if (sent < 20) set_rx(mk(300 + sent, 1'b1), 1'b1);
            else rx_valid = 1'b0;
            ntests++;
            if (b_tx_in_pkt !== 1'b0) begin
                nfail++;
                $display("FAIL sat_in_pkt[%0d]: got %b want 0", cyc, b_tx_in_pkt);
            end
            if (b_tx_valid && tx_ready) got++;
            if (rx_valid && b_rx_ready) sent++;
            tick();
        end
        rx_valid = 1'b0;
        ntests++;
        if (b_cnt_pkts !== 4'hF || cnt_pkts !== 16'd20) begin
            nfail++;
            $display("FAIL sat_pkts: narrow=%0d wide=%0d want 15 20", b_cnt_pkts, cnt_pkts);
        end
        set_rx(mk(400, 1'b1), 1'b1);
        tick();
        rx_valid = 1'b0;
        ntests++;
        if (tx_valid !== 1'b1 || tx_last !== 1'b1) begin
            nfail++;
            $display("FAIL clr_setup: valid=%b last=%b want 1 1", tx_valid, tx_last);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        ntests++;
        if (cnt_pkts !== 16'd0 || b_cnt_pkts !== 4'd0) begin
            nfail++;
            $display("FAIL clr_prio: wide=%0d narrow=%0d want 0 0", cnt_pkts, b_cnt_pkts);
        end
    endtask

    task automatic test_reset_mid();
        int rcvd = 0;
        tx_ready = 1'b1;
        set_rx(mk(500, 1'b0), 1'b1);
        tick();
        set_rx(mk(501, 1'b0), 1'b1);
        tick();
        tx_ready = 1'b0;
        set_rx(mk(502, 1'b0), 1'b1);
        tick();
        rx_valid = 1'b0;
        ntests++;
        if (rx_ready !== 1'b0 || tx_in_pkt !== 1'b1 || tx_valid !== 1'b1) begin
            nfail++;
            $display("FAIL mid_setup: rx_ready=%b in_pkt=%b valid=%b want 0 1 1",
                     rx_ready, tx_in_pkt, tx_valid);
        end
        rst = 1'b1;
        tick();
        ntests++;
        if (tx_valid !== 1'b0 || cnt_pkts !== '0 || cnt_stall !== '0 || tx_in_pkt !== 1'b0) begin
            nfail++;
            $display("FAIL mid_reset: valid=%b pkts=%0d stall=%0d in_pkt=%b want 0 0 0 0",
                     tx_valid, cnt_pkts, cnt_stall, tx_in_pkt);
        end
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 2) set_rx(mk(600 + cyc, cyc == 1), 1'b1);
            else rx_valid = 1'b0;
            if (tx_valid && tx_ready) begin
                ntests++;
                if (tx_word !== mk(600 + rcvd, rcvd == 1)) begin
                    nfail++;
                    $display("FAIL mid_word[%0d]: got %h want %h",
                             rcvd, tx_word, mk(600 + rcvd, rcvd == 1));
                end
                rcvd++;
            end
            tick();
        end
        ntests++;
        if (rcvd != 2 || cnt_pkts !== 16'd1 || tx_in_pkt !== 1'b0) begin
            nfail++;
            $display("FAIL mid_after: rcvd=%0d pkts=%0d in_pkt=%b want 2 1 0",
                     rcvd, cnt_pkts, tx_in_pkt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
